// File: rtl/mem_row_streamer.sv
// Read-side row sequencer: issues consecutive memory reads, absorbs the one-cycle
// read latency through a 2-entry skid FIFO and presents rows as a valid/ready stream.
module mem_row_streamer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      row_count,
    output logic             busy,
    output logic             done,
    output logic             mem_rden,
    output logic [AW-1:0]    mem_rdaddress,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_last_addr;
    logic [AW:0]      r_remaining;
    logic [AW:0]      r_issued;
    logic             r_pending;
    logic             r_pend_last;
    logic [WIDTH-1:0] r_fifo_data [2];
    logic [1:0]       r_fifo_last;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;

    logic             w_pop;
    logic             w_rden;
    logic             w_done;
    logic             w_start_acc;
    logic             w_final_rd;
    logic [2:0]       w_level;
    logic [2:0]       w_limit;
    logic [AW:0]      w_count_sat;

    assign w_pop       = (r_occ != 2'd0) & out_ready;
    assign w_level     = {1'b0, r_occ} + {2'b00, r_pending};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign w_rden      = (r_state == RUN) & (r_issued < r_remaining) & (w_level < w_limit);
    assign w_start_acc = (r_state == IDLE) & start;
    assign w_final_rd  = ((r_issued + CNT_ONE) == r_remaining);
    assign w_count_sat = (row_count > DEPTH_W) ? DEPTH_W : row_count;

    assign busy          = (r_state == RUN);
    assign done          = w_done;
    assign mem_rden      = w_rden;
    assign mem_rdaddress = w_rden ? r_addr : r_last_addr;
    assign out_valid     = (r_occ != 2'd0);
    assign out_data      = r_fifo_data[r_rd_ptr];
    assign out_last      = r_fifo_last[r_rd_ptr];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and done pulse; a zero-length transfer finishes in its first RUN cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if ((r_remaining == {(AW+1){1'b0}}) || (w_pop && out_last)) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Read issue bookkeeping and the one-cycle latency tracker.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= {AW{1'b0}};
            r_last_addr <= {AW{1'b0}};
            r_remaining <= {(AW+1){1'b0}};
            r_issued    <= {(AW+1){1'b0}};
            r_pending   <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_addr      <= base_addr;
                r_remaining <= w_count_sat;
                r_issued    <= {(AW+1){1'b0}};
            end else if (w_rden) begin
                r_addr      <= (r_addr == ADDR_MAX) ? {AW{1'b0}} : (r_addr + ADDR_ONE);
                r_issued    <= r_issued + CNT_ONE;
            end
            if (w_rden) begin
                r_last_addr <= r_addr;
            end
            r_pending   <= w_rden;
            r_pend_last <= w_rden & w_final_rd;
        end
    end

    // Two-entry FIFO of {data, last}; push and pop may coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fifo_data[0] <= {WIDTH{1'b0}};
            r_fifo_data[1] <= {WIDTH{1'b0}};
            r_fifo_last    <= 2'b00;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_occ          <= 2'd0;
        end else begin
            if (r_pending) begin
                r_fifo_data[r_wr_ptr] <= mem_q;
                r_fifo_last[r_wr_ptr] <= r_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (r_pending && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!r_pending && w_pop) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_row_streamer.sv
// Directed bench for mem_row_streamer: behavioural memory, stream monitor and
// hand-derived expectations for each scenario.
module tb_mem_row_streamer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      row_count;
    logic             busy;
    logic             done;
    logic             mem_rden;
    logic [AW-1:0]    mem_rdaddress;
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    logic [WIDTH-1:0] tb_mem [DEPTH];
    logic [8:0]       beats [$];
    logic [AW-1:0]    addrs [$];
    int               n_checks;
    int               n_errors;
    int               done_cnt;
    int               outstanding;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;

    mem_row_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .row_count     (row_count),
        .busy          (busy),
        .done          (done),
        .mem_rden      (mem_rden),
        .mem_rdaddress (mem_rdaddress),
        .mem_q         (mem_q),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory model with mem[i] = i.
    always @(posedge clk) begin
        if (mem_rden) mem_q <= tb_mem[mem_rdaddress];
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: records reads and accepted beats, checks stall stability and occupancy bound.
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", int'(out_valid), 1);
                check_val("stall_data", int'(out_data), int'(prev_data));
            end
            if (busy) begin
                check_val("occ_bound",
                          int'((outstanding + int'(mem_rden) - int'(out_valid && out_ready)) <= 2), 1);
            end
            if (out_valid && out_ready) beats.push_back({out_last, out_data});
            if (mem_rden) addrs.push_back(mem_rdaddress);
            if (done) done_cnt++;
            outstanding = outstanding + int'(mem_rden) - int'(out_valid && out_ready);
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
        end
    end

    // Called just after a rising edge; returns just after edge 0 of the new transfer.
    task automatic start_xfer(input int base, input int cnt);
        beats.delete();
        addrs.delete();
        done_cnt  = 0;
        base_addr = AW'(base);
        row_count = (AW+1)'(cnt);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1'b1;
        check_val("done_seen", done_cnt, 1);
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_busy", int'(busy), 0);
        check_val("single_done", done_cnt, 1);
    endtask

    task automatic check_stream(input int base, input int n);
        int exp;
        check_val("n_beats", beats.size(), n);
        check_val("n_reads", addrs.size(), n);
        for (int i = 0; i < n; i++) begin
            exp = (base + i) % DEPTH;
            if (i < beats.size()) begin
                check_val("beat_data", int'(beats[i][7:0]), exp);
                check_val("beat_last", int'(beats[i][8]), int'(i == n - 1));
            end
            if (i < addrs.size()) check_val("rd_addr", int'(addrs[i]), exp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        done_cnt    = 0;
        outstanding = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        mem_q       = '0;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = WIDTH'(i);
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        row_count = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_rden", int'(mem_rden), 0);
        check_val("rst_addr", int'(mem_rdaddress), 0);
        check_val("rst_valid", int'(out_valid), 0);
        check_val("rst_data", int'(out_data), 0);
        check_val("rst_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer, cycle-accurate: reads 4..8 in cycles 1..5, beats in cycles 3..7.
        start_xfer(4, 5);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_val("b_rden", int'(mem_rden), int'(c <= 5));
            check_val("b_addr", int'(mem_rdaddress), (c <= 5) ? c + 3 : 8);
            check_val("b_valid", int'(out_valid), int'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) check_val("b_data", int'(out_data), c + 1);
            check_val("b_last", int'(out_last && out_valid), int'(c == 7));
            check_val("b_done", int'(done), int'(c == 7));
            check_val("b_busy", int'(busy), int'(c <= 7));
        end
        @(posedge clk);
        #1;
        check_stream(4, 5);

        // Address wrap-around.
        start_xfer(62, 4);
        wait_done(0, 50);
        check_stream(62, 4);

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        start_xfer(10, 6);
        wait_done(1, 200);
        check_stream(10, 6);

        // Zero-length transfer: done in cycle 1, nothing read or streamed.
        start_xfer(7, 0);
        @(negedge clk);
        check_val("z_done", int'(done), 1);
        check_val("z_busy", int'(busy), 1);
        check_val("z_rden", int'(mem_rden), 0);
        @(negedge clk);
        check_val("z_done2", int'(done), 0);
        check_val("z_busy2", int'(busy), 0);
        check_val("z_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check_val("z_beats", beats.size(), 0);
        check_val("z_reads", addrs.size(), 0);
        check_val("z_done_cnt", done_cnt, 1);

        // Oversize count saturates to 64 rows.
        start_xfer(0, 100);
        wait_done(0, 200);
        check_stream(0, 64);

        // Start during RUN is ignored.
        start_xfer(20, 5);
        @(posedge clk);
        #1;
        base_addr = AW'(40);
        row_count = (AW+1)'(9);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0, 50);
        repeat (4) @(posedge clk);
        #1;
        check_val("ign_busy", int'(busy), 0);
        check_val("ign_done_cnt", done_cnt, 1);
        check_stream(20, 5);

        // Reset one cycle after the first read issues; the late read data must be dropped.
        start_xfer(30, 8);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("mr_busy", int'(busy), 0);
        check_val("mr_done", int'(done), 0);
        check_val("mr_rden", int'(mem_rden), 0);
        check_val("mr_addr", int'(mem_rdaddress), 0);
        check_val("mr_valid", int'(out_valid), 0);
        check_val("mr_data", int'(out_data), 0);
        check_val("mr_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("mr_no_late", int'(out_valid), 0);
        end
        check_val("mr_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        start_xfer(50, 3);
        wait_done(0, 50);
        check_stream(50, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_row_streamer.md
Name: mem_row_streamer

Overview:
- Read-side sequencer placed directly downstream of the row-storage memory in the Gaussian elimination datapath.
- On `start`, it issues `row_count` consecutive reads beginning at `base_addr` and absorbs the memory's one-cycle registered read latency.
- It presents the rows to the elimination array as a valid/ready stream, with a last-row marker and full throughput under backpressure.

Parameters:
- WIDTH, 8, row width in bits; equals the memory data width.
- DEPTH, 64, memory depth in rows.
- AW, `CLOG2(DEPTH)`, address width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  AW  first row address; captured on accepted start.
- row_count  in  AW+1  number of rows to stream; captured on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the final row is accepted downstream.
- mem_rden  out  1  memory read enable.
- mem_rdaddress  out  AW  memory read address.
- mem_q  in  WIDTH  memory read data; valid the cycle after `mem_rden`.
- out_data  out  WIDTH  streamed row.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts when high with `out_valid`.
- out_last  out  1  current beat is the final row of the transfer.

Behaviour:
- Reset values: `busy`=0, `done`=0, `mem_rden`=0, `mem_rdaddress`=0, `out_valid`=0, `out_data`=0, `out_last`=0. State is IDLE, the FIFO is empty and `pending` is 0.
- Reset asserted mid-transfer aborts the transfer immediately. Any `mem_q` arriving after reset release is discarded. No `done` pulse is generated.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on `start`. The block captures `base_addr` into `addr` and `min(row_count, DEPTH)` into `remaining`, and clears `issued`.
  - RUN -> IDLE on the beat where `out_valid & out_ready & out_last`. `done`=1 for exactly that cycle.
  - `start` while in RUN is ignored.
- `row_count`=0: RUN is entered, no reads are issued and no beats are produced. `done` pulses in the first RUN cycle, then the FSM returns to IDLE.
- `row_count` > DEPTH saturates to DEPTH.
- Buffering:
  - A 2-entry FIFO holds {data, last}.
  - `pending` is a 1-bit register meaning a read was issued last cycle. When it is 1, `mem_q` is pushed into the FIFO.
  - The `last` tag for a read is set when that read is the final one of the transfer; the tag is delayed alongside `pending`.
- Read issue is combinational from registered state and `out_ready`:
  - `mem_rden` = RUN & (`issued` < `remaining`) & (`occ` + `pending` − `pop` < 2), where `pop` = `out_valid & out_ready`.
  - `mem_rdaddress` = `addr` whenever `mem_rden`=1; otherwise it holds its last value (0 after reset).
- Address advance: `addr` increments on each issued read and wraps from DEPTH−1 to 0, including for non-power-of-two DEPTH.
- Outputs:
  - `out_data` and `out_last` come from the FIFO head.
  - `out_valid` = (`occ` != 0).
  - Data is held stable while `out_valid & !out_ready`.
- Simultaneous push and pop in the same cycle are both honoured; `occ` is unchanged.
- The FIFO never overflows: the issue rule guarantees `occ` + `pending` ≤ 2.
- Latency: `start` sampled at edge 0 → `mem_rden` high in cycle 1 → `out_valid` high in cycle 3.
- Throughput: with `out_ready` held high, one row per cycle is sustained. A transfer of N≥1 rows has `done` in cycle N+2.
- `busy` = (state == RUN). It is high from cycle 1 through the `done` cycle inclusive.

Test Plan:
- Basic transfer: memory preloaded with mem[i]=i; `base_addr`=4, `row_count`=5, `out_ready`=1. Expect reads at addresses 4..8 in cycles 1..5; `out_data` 4,5,6,7,8 in cycles 3..7; `out_last` only on value 8; `done` in cycle 7.
- Wrap-around: DEPTH=64, `base_addr`=62, `row_count`=4. Expect addresses 62,63,0,1 and `out_data` streamed in that order.
- Backpressure: `row_count`=6 with `out_ready` toggling 1,0,0,1,... Expect no lost or duplicated rows and `occ`+`pending` never exceeding 2. `out_data` must hold steady while stalled, and `mem_rden` must be low whenever the FIFO is full and no pop occurs.
- Zero and oversize counts:
  - `row_count`=0 → no `mem_rden`, `out_valid` never asserted, `done` in cycle 1.
  - `row_count`=100 → exactly 64 beats.
- Ignored start: assert `start` in the middle of a RUN with different `base_addr`/`row_count`. The original transfer completes unchanged and no second transfer starts.
- Mid-transfer reset: assert `reset` one cycle after a read is issued. All outputs go to 0 asynchronously. After release, the late `mem_q` is not emitted; a new transfer then runs correctly from its own `base_addr`.
